// File: rtl/fwnoc_router_wh_arbiter_pkg.sv
// Shared definitions for the wormhole egress arbiter: header field positions,
// arbiter FSM states and a header LEN extractor.
package fwnoc_router_wh_arbiter_pkg;

    localparam int unsigned FLIT_WIDTH = 32;
    localparam int unsigned LEN_LSB    = 0;
    localparam int unsigned LEN_WIDTH  = 8;
    localparam int unsigned DSTX_LSB   = 24;
    localparam int unsigned DSTY_LSB   = 26;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StBody
    } fwnoc_arb_state_e;

    function automatic logic [LEN_WIDTH-1:0] hdr_len(input logic [FLIT_WIDTH-1:0] flit);
        return flit[LEN_LSB +: LEN_WIDTH];
    endfunction

endpackage

// File: rtl/fwnoc_router_wh_arbiter_if.sv
// Single ready/valid flit channel; master drives valid/data, slave drives ready.
interface fwnoc_router_wh_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fwnoc_router_wh_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker: first requester at or after ptr,
// wrapping 3->0.
module fwnoc_router_wh_arbiter_rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] winner,
    output logic       any
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/fwnoc_router_wh_arbiter.sv
// Wormhole round-robin arbiter for one egress port: locks onto one of four
// ingress streams from header through last payload word.
module fwnoc_router_wh_arbiter
    import fwnoc_router_wh_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = fwnoc_router_wh_arbiter_pkg::FLIT_WIDTH,
    parameter int unsigned LEN_WIDTH  = fwnoc_router_wh_arbiter_pkg::LEN_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    fwnoc_router_wh_arbiter_if.slave  i0,
    fwnoc_router_wh_arbiter_if.slave  i1,
    fwnoc_router_wh_arbiter_if.slave  i2,
    fwnoc_router_wh_arbiter_if.slave  i3,
    fwnoc_router_wh_arbiter_if.master e,
    output logic                      busy,
    output logic [1:0]                grant
);

    fwnoc_arb_state_e       state_q, state_d;
    logic [1:0]             ptr_q, ptr_d;
    logic [1:0]             grant_q, grant_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;

    logic [3:0]             req;
    logic [1:0]             winner;
    logic                   any;
    logic                   sel_valid;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [LEN_WIDTH-1:0]   sel_len;
    logic                   locked;
    logic                   hs;

    assign req = {i3.valid, i2.valid, i1.valid, i0.valid};

    fwnoc_router_wh_arbiter_rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        case (grant_q)
            2'd0:    begin sel_valid = i0.valid; sel_data = i0.data; end
            2'd1:    begin sel_valid = i1.valid; sel_data = i1.data; end
            2'd2:    begin sel_valid = i2.valid; sel_data = i2.data; end
            default: begin sel_valid = i3.valid; sel_data = i3.data; end
        endcase
    end

    assign locked  = (state_q != StIdle);
    assign sel_len = sel_data[LEN_LSB +: LEN_WIDTH];
    // A dropped upstream valid mid-packet simply produces no handshake.
    assign hs      = locked & sel_valid & e.ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (any) begin
                    grant_d = winner;
                    ptr_d   = winner + 2'd1;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (hs) begin
                    if (sel_len == '0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d   = sel_len;
                        state_d = StBody;
                    end
                end
            end
            StBody: begin
                if (hs) begin
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = locked;
        grant    = grant_q;
        e.valid  = locked & sel_valid;
        e.data   = locked ? sel_data : '0;
        i0.ready = locked && (grant_q == 2'd0) && e.ready;
        i1.ready = locked && (grant_q == 2'd1) && e.ready;
        i2.ready = locked && (grant_q == 2'd2) && e.ready;
        i3.ready = locked && (grant_q == 2'd3) && e.ready;
    end

endmodule

// File: tb/tb_fwnoc_router_wh_arbiter.sv
// Scoreboard bench for the wormhole egress arbiter: per-input drivers push
// expected flits, a negedge monitor checks against a packet-level model.
module tb_fwnoc_router_wh_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  iv;
    logic [31:0] id [4];
    logic [3:0]  ir;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_data;
    logic        busy;
    logic [1:0]  grant;

    always #5 clock = ~clock;

    fwnoc_router_wh_arbiter_if #(.DATA_WIDTH(32)) if_i0 ();
    fwnoc_router_wh_arbiter_if #(.DATA_WIDTH(32)) if_i1 ();
    fwnoc_router_wh_arbiter_if #(.DATA_WIDTH(32)) if_i2 ();
    fwnoc_router_wh_arbiter_if #(.DATA_WIDTH(32)) if_i3 ();
    fwnoc_router_wh_arbiter_if #(.DATA_WIDTH(32)) if_e ();

    assign if_i0.valid = iv[0];
    assign if_i0.data  = id[0];
    assign if_i1.valid = iv[1];
    assign if_i1.data  = id[1];
    assign if_i2.valid = iv[2];
    assign if_i2.data  = id[2];
    assign if_i3.valid = iv[3];
    assign if_i3.data  = id[3];
    assign ir          = {if_i3.ready, if_i2.ready, if_i1.ready, if_i0.ready};
    assign if_e.ready  = e_ready;
    assign e_valid     = if_e.valid;
    assign e_data      = if_e.data;

    fwnoc_router_wh_arbiter #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .i0    (if_i0),
        .i1    (if_i1),
        .i2    (if_i2),
        .i3    (if_i3),
        .e     (if_e),
        .busy  (busy),
        .grant (grant)
    );

    // Stimulus / scoreboard state
    logic [31:0] src_q [4][$];
    logic [31:0] exp_q [4][$];
    logic        erdy_q[$];
    int          glog[$];
    logic [3:0]  active;
    bit          rand_mode, stab_en, mon_en;
    int          n_checks, n_err, dut_hs;

    // Packet-level reference model
    bit          m_busy, m_hdr;
    int          m_grant, m_ptr, m_rem;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_hdr(input int len);
        logic [31:0] r;
        r      = $urandom();
        r[7:0] = 8'(len);
        return r;
    endfunction

    task automatic push_pkt(input int k, input int len);
        src_q[k].push_back(mk_hdr(len));
        for (int j = 0; j < len; j++) src_q[k].push_back($urandom());
    endtask

    task automatic sync();
        @(posedge clock);
        #2;
    endtask

    task automatic send_flit(input int k, input logic [31:0] f, input bit drops);
        bit acc;
        exp_q[k].push_back(f);
        id[k] = f;
        acc   = 1'b0;
        while (!acc) begin
            iv[k] = (drops && $urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            @(negedge clock);
            acc = iv[k] && ir[k];
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_src(input int k);
        logic [31:0] f;
        int          len;
        @(posedge clock);
        #1;
        forever begin
            if (src_q[k].size() == 0) begin
                @(posedge clock);
                #1;
            end else begin
                active[k] = 1'b1;
                if (rand_mode) repeat ($urandom_range(0, 2)) begin
                    @(posedge clock);
                    #1;
                end
                f   = src_q[k].pop_front();
                len = int'(f[7:0]);
                send_flit(k, f, 1'b0);
                for (int j = 0; j < len; j++) begin
                    f = src_q[k].pop_front();
                    send_flit(k, f, rand_mode);
                end
                iv[k]     = 1'b0;
                active[k] = 1'b0;
            end
        end
    endtask

    task automatic drive_eready();
        forever begin
            @(posedge clock);
            #1;
            if (erdy_q.size() != 0) e_ready = erdy_q.pop_front();
            else if (rand_mode)     e_ready = ($urandom_range(0, 3) != 0);
            else                    e_ready = 1'b1;
        end
    endtask

    function automatic bit all_idle();
        for (int k = 0; k < 4; k++)
            if (src_q[k].size() != 0 || exp_q[k].size() != 0 || active[k]) return 1'b0;
        return !m_busy;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int c;
        c = 0;
        while (!all_idle() && c < budget) begin
            @(posedge clock);
            c++;
        end
        n_checks++;
        if (c >= budget) begin
            n_err++;
            $display("FAIL %s_timeout: got busy after %0d cycles expected drained", name, c);
        end
    endtask

    // Monitor: compares DUT against the model, then advances the model.
    initial begin
        bit          hs_m, prev_stall;
        logic [31:0] prev_data, exp_f;
        logic [3:0]  exp_rdy;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clock);
            if (!mon_en) begin
                prev_stall = 1'b0;
            end else begin
                hs_m = m_busy && iv[m_grant] && e_ready;
                chk("busy", 32'(busy), 32'(m_busy));
                if (m_busy) chk("grant", 32'(grant), 32'(m_grant));
                chk("e_valid", 32'(e_valid), 32'(m_busy && iv[m_grant]));
                exp_rdy = (m_busy && e_ready) ? (4'b1 << m_grant) : 4'b0;
                chk("ready", 32'(ir), 32'(exp_rdy));
                if (!m_busy) chk("e_data_idle", e_data, 32'h0);
                if (stab_en && prev_stall) begin
                    chk("stall_valid", 32'(e_valid), 32'h1);
                    chk("stall_data", e_data, prev_data);
                end
                prev_stall = e_valid && !e_ready;
                prev_data  = e_data;
                if (e_valid && e_ready) dut_hs++;
                if (hs_m) begin
                    exp_f = '0;
                    if (exp_q[m_grant].size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL underflow: got handshake on input %0d expected none", m_grant);
                    end else begin
                        exp_f = exp_q[m_grant].pop_front();
                        chk("e_data", e_data, exp_f);
                    end
                    if (m_hdr) begin
                        glog.push_back(int'(grant));
                        m_hdr = 1'b0;
                        if (exp_f[7:0] == 8'd0) m_busy = 1'b0;
                        else                    m_rem  = int'(exp_f[7:0]);
                    end else begin
                        m_rem--;
                        if (m_rem == 0) m_busy = 1'b0;
                    end
                end else if (!m_busy && iv != 4'b0) begin
                    for (int j = 0; j < 4; j++) begin
                        if (iv[(m_ptr + j) % 4]) begin
                            m_grant = (m_ptr + j) % 4;
                            break;
                        end
                    end
                    m_busy = 1'b1;
                    m_hdr  = 1'b1;
                    m_ptr  = (m_grant + 1) % 4;
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        e_ready   = 1'b1;
        iv        = '0;
        for (int k = 0; k < 4; k++) id[k] = '0;
        active    = '0;
        rand_mode = 1'b0;
        stab_en   = 1'b1;
        mon_en    = 1'b0;
        n_checks  = 0;
        n_err     = 0;
        dut_hs    = 0;
        m_busy    = 1'b0;
        m_hdr     = 1'b0;
        m_grant   = 0;
        m_ptr     = 0;
        m_rem     = 0;

        // All four inputs hold header-only packets from reset.
        for (int k = 0; k < 4; k++) begin
            push_pkt(k, 0);
            push_pkt(k, 0);
        end
        fork
            drive_src(0);
            drive_src(1);
            drive_src(2);
            drive_src(3);
            drive_eready();
        join_none

        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_e_valid", 32'(e_valid), 32'h0);
        chk("rst_ready", 32'(ir), 32'h0);
        chk("rst_e_data", e_data, 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);

        repeat (3) @(posedge clock);
        #2;
        reset  = 1'b1;
        mon_en = 1'b1;
        wait_idle("rr_order", 200);
        chk("rr_count", 32'(glog.size()), 32'd8);
        for (int j = 0; j < 8; j++)
            if (j < glog.size()) chk("rr_grant", 32'(glog[j]), 32'(j % 4));

        // i0 alone, LEN=2
        sync();
        dut_hs = 0;
        push_pkt(0, 2);
        wait_idle("single", 100);
        chk("single_hs", 32'(dut_hs), 32'd3);

        // ptr=1 now: i1 wins, then i2 ahead of i0
        sync();
        glog.delete();
        push_pkt(1, 3);
        push_pkt(2, 0);
        push_pkt(0, 0);
        wait_idle("lock", 100);
        chk("lock_count", 32'(glog.size()), 32'd3);
        if (glog.size() == 3) begin
            chk("lock_g0", 32'(glog[0]), 32'd1);
            chk("lock_g1", 32'(glog[1]), 32'd2);
            chk("lock_g2", 32'(glog[2]), 32'd0);
        end

        // i3 LEN=4 under egress backpressure; the first entry covers IDLE
        sync();
        dut_hs = 0;
        push_pkt(3, 4);
        erdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        wait_idle("stall", 100);
        chk("stall_hs", 32'(dut_hs), 32'd5);

        // Maximum length packet
        sync();
        dut_hs = 0;
        push_pkt(0, 255);
        wait_idle("maxlen", 600);
        chk("maxlen_hs", 32'(dut_hs), 32'd256);

        // Randomized traffic with backpressure and mid-packet valid drops
        sync();
        stab_en   = 1'b0;
        rand_mode = 1'b1;
        for (int p = 0; p < 40; p++)
            push_pkt($urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 6));
        wait_idle("random", 20000);
        rand_mode = 1'b0;
        stab_en   = 1'b1;

        // Async reset mid-body (cnt=5 after header + 3 payload handshakes)
        sync();
        mon_en = 1'b0;
        id[1]  = mk_hdr(8);
        iv[1]  = 1'b1;
        repeat (5) @(posedge clock);
        #2;
        chk("pre_rst_busy", 32'(busy), 32'h1);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_e_valid", 32'(e_valid), 32'h0);
        chk("arst_ready", 32'(ir), 32'h0);
        chk("arst_e_data", e_data, 32'h0);
        chk("arst_grant", 32'(grant), 32'h0);
        iv[1] = 1'b0;
        sync();
        reset   = 1'b1;
        m_busy  = 1'b0;
        m_hdr   = 1'b0;
        m_ptr   = 0;
        m_grant = 0;
        glog.delete();
        mon_en  = 1'b1;
        sync();
        push_pkt(2, 3);
        wait_idle("post_rst", 100);
        chk("post_rst_count", 32'(glog.size()), 32'd1);
        if (glog.size() == 1) chk("post_rst_grant", 32'(glog[0]), 32'd2);

        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
